// File: rtl/clk_gate_ctrl.sv
// Per-channel automatic clock-gating controller driving clk_icg enables.
// Optional feature: define CLK_GATE_CTRL_STAT_EN for per-channel gated-cycle statistics.
module clk_gate_ctrl #(
  parameter int CH_NUM     = 4,
  parameter int IDLE_WIDTH = 8,
  parameter int WAKE_CYC   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [IDLE_WIDTH-1:0] idle_thr_i,
  input  logic [CH_NUM-1:0]     busy_i,
  input  logic [CH_NUM-1:0]     wake_req_i,
  input  logic [CH_NUM-1:0]     force_on_i,
`ifdef CLK_GATE_CTRL_STAT_EN
  input  logic                  stat_clr_i,
  input  logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] stat_sel_i,
  output logic [31:0]           stat_cnt_o,
`endif
  output logic [CH_NUM-1:0]     gate_en_o,
  output logic [CH_NUM-1:0]     ready_o,
  output logic [CH_NUM-1:0]     gated_o
);

  localparam int WCNT_W = $clog2(WAKE_CYC + 1);
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYC - 1);

  // State encoding is {gate_en, ready, gated}, so outputs are the state flops themselves.
  localparam logic [2:0] ST_RUN   = 3'b110;
  localparam logic [2:0] ST_GATED = 3'b001;
  localparam logic [2:0] ST_WAKE  = 3'b100;

  logic              thr_zero;
  logic [CH_NUM-1:0] hold;

  assign thr_zero = (idle_thr_i == '0);
  assign hold     = {CH_NUM{~en_i | thr_zero}} | busy_i | wake_req_i | force_on_i;

`ifdef CLK_GATE_CTRL_STAT_EN
  logic [31:0] stat_arr [CH_NUM];
`endif

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [2:0]            st_q;
    logic [IDLE_WIDTH-1:0] cnt_q;
    logic [WCNT_W-1:0]     wcnt_q;
    logic [IDLE_WIDTH:0]   cnt_inc;

    // One extra bit so cnt+1 cannot wrap before the >= compare.
    assign cnt_inc = {1'b0, cnt_q} + (IDLE_WIDTH + 1)'(1);

    // NOTE: sequential state uses non-blocking assignments so every channel samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        st_q   <= ST_RUN;
        cnt_q  <= '0;
        wcnt_q <= '0;
      end else begin
        case (st_q)
          ST_RUN: begin
            if (hold[c]) begin
              cnt_q <= '0;
            end else if (cnt_inc >= {1'b0, idle_thr_i}) begin
              st_q  <= ST_GATED;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_inc[IDLE_WIDTH-1:0];
            end
          end
          ST_GATED: begin
            if (hold[c]) begin
              st_q   <= ST_WAKE;
              wcnt_q <= '0;
            end
          end
          ST_WAKE: begin
            // Settling window runs to completion regardless of inputs.
            if (wcnt_q == WAKE_LAST) begin
              st_q  <= ST_RUN;
              cnt_q <= '0;
            end else begin
              wcnt_q <= wcnt_q + WCNT_W'(1);
            end
          end
          default: begin
            st_q  <= ST_RUN;
            cnt_q <= '0;
          end
        endcase
      end
    end

    assign gate_en_o[c] = st_q[2];
    assign ready_o[c]   = st_q[1];
    assign gated_o[c]   = st_q[0];

`ifdef CLK_GATE_CTRL_STAT_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        stat_q <= '0;
      end else if (stat_clr_i) begin
        stat_q <= '0;
      end else if (st_q == ST_GATED && stat_q != '1) begin
        stat_q <= stat_q + 32'd1;
      end
    end

    assign stat_arr[c] = stat_q;
`endif
  end

`ifdef CLK_GATE_CTRL_STAT_EN
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    stat_cnt_o = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (int'(stat_sel_i) == i) stat_cnt_o = stat_arr[i];
    end
  end
`endif

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Per-channel automatic clock-gating controller. It drives the `en_i` pin of one `clk_icg` cell per gated sub-domain, based on idle detection and wake requests. It sits in the always-on clock/reset unit, clocked by the ungated source clock. It turns a sub-domain's clock off after a programmable number of idle cycles. On a wake request it restores the clock and holds off requesters until a fixed settling window has elapsed.

## Interface
- `CH_NUM`, default 4: number of gated channels; legal range 1..16.
- `IDLE_WIDTH`, default 8: width of the idle threshold and of each idle counter.
- `WAKE_CYC`, default 2: cycles between re-enabling a clock and asserting ready; must be ≥1.

Ports:
- `clk_i`  in  1  ungated source clock.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  global auto-gating enable; 0 keeps all channels running.
- `idle_thr_i`  in  IDLE_WIDTH  consecutive idle cycles required before gating; 0 disables gating.
- `busy_i`  in  CH_NUM  channel activity, synchronous to `clk_i`.
- `wake_req_i`  in  CH_NUM  request to restore a channel's clock; level-sensitive.
- `force_on_i`  in  CH_NUM  per-channel override that keeps the clock running.
- `gate_en_o`  out  CH_NUM  registered; connects to `clk_icg.en_i` of each channel.
- `ready_o`  out  CH_NUM  registered; channel clock is running and stable.
- `gated_o`  out  CH_NUM  registered; channel is in the GATED state.

## Operation
- Each channel has an independent FSM with states RUN, GATED and WAKE. Each channel also has an idle counter `cnt` (IDLE_WIDTH bits) and a wake counter (`$clog2(WAKE_CYC+1)` bits).
- Define `hold = ~en_i | busy_i[c] | wake_req_i[c] | force_on_i[c] | (idle_thr_i == 0)`.
- **RUN** (`gate_en`=1, `ready`=1, `gated`=0):
  - If `hold`, `cnt` ← 0.
  - Otherwise, if `cnt + 1 >= idle_thr_i`, go to GATED and set `cnt` ← 0.
  - Otherwise, `cnt` ← `cnt + 1`.
- **GATED** (`gate_en`=0, `ready`=0, `gated`=1):
  - If `hold`, go to WAKE with the wake counter ← 0.
  - Otherwise, stay in GATED.
- **WAKE** (`gate_en`=1, `ready`=0, `gated`=0):
  - The wake counter increments every cycle.
  - When it reaches WAKE_CYC-1, go to RUN with `cnt` ← 0.
  - WAKE is not abortable: inputs are ignored until it completes.
- `idle_thr_i` is compared live, with ≥. Lowering it mid-count gates on the next idle cycle. Raising it extends the count.
- `busy_i` asserted while in GATED is treated as a wake. This is a protocol violation by the requester, but it must be recovered from safely.
- All outputs are taken directly from the state register, with no combinational paths from inputs. The ICG's internal latch handles glitch-free gating.
- Reset, asserted at any time: every channel goes to RUN with `cnt`=0. Outputs become `gate_en_o`='1, `ready_o`='1, `gated_o`='0 asynchronously.

## Timing
- Gating latency: idle sampled on edges t .. t+N-1, where N = `idle_thr_i` → `gate_en_o` falls after edge t+N-1.
  - With N=1, a single idle edge gates the channel.
- Wake latency: `hold` first sampled on edge t while GATED →
  - `gate_en_o` rises after edge t;
  - `ready_o` rises after edge t+WAKE_CYC.
- A busy/wake event on the same edge that the threshold would be reached has priority: the channel stays in RUN and `cnt` is cleared.
- Channels never interact. Simultaneous events on different channels are handled in the same cycle.
- Counters never wrap: `cnt` stops advancing once the transition to GATED fires.

## Configuration
- Macro `CLK_GATE_CTRL_STAT_EN`.
- Defined: adds the following ports.
  - `stat_clr_i` (in, 1).
  - `stat_sel_i` (in, `$clog2(CH_NUM)`; width 1 when CH_NUM=1).
  - `stat_cnt_o` (out, 32).
- Each channel keeps a 32-bit saturating counter of cycles spent in GATED. The counter resets to 0 and is cleared synchronously by `stat_clr_i`; clear wins over increment.
- `stat_cnt_o` is a combinational mux of the counter selected by `stat_sel_i`.
- Undefined: the ports and counters are absent, and FSM behaviour is identical.

## Test plan
- Reset: assert `rst_n_i`=0 mid-operation with channel 0 GATED → `gate_en_o`=4'hF, `ready_o`=4'hF and `gated_o`=0 immediately.
- Idle gating: `en_i`=1, `idle_thr_i`=5, channel 1 idle from edge 10 → `gate_en_o[1]` falls after edge 14 and `gated_o[1]`=1. Channel 1 busy at edge 13 instead → it stays in RUN, and the count restarts from edge 14.
- Wake: WAKE_CYC=2, GATED channel 2, `wake_req_i[2]` pulsed one cycle at edge 20 → `gate_en_o[2]`=1 after edge 20 and `ready_o[2]`=1 after edge 22.
- Overrides: `idle_thr_i`=0, or `en_i`=0, or `force_on_i[3]`=1 → no gating for 1000 idle cycles. Dropping `en_i` while channels are GATED → all of them wake.
- Threshold change: `cnt`=6 with `idle_thr_i` changed from 10 to 4 → the channel gates after the next idle edge.
- With `CLK_GATE_CTRL_STAT_EN`: channel 0 gated for 100 cycles → `stat_cnt_o`=100 with `stat_sel_i`=0. `stat_clr_i` asserted together with an increment → the counter reads 0 next cycle.
